// File: rtl/iterate_square.sv
`default_nettype none
// ============================================================================
// Module   : iterate_square
// Brief    : Squares an unpacked floating-point operand with a serial
//            shift-add multiplier. The result is truncated and never negative.
// Revision : 1.0 - initial release
// ============================================================================
module iterate_square #(
    parameter int ITER_MAX = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                n_valid,
    input  logic                is_nan_in,
    input  logic                is_pinf_in,
    input  logic                is_ninf_in,
    input  logic                is_num,
    input  logic                sign_in,
    input  logic [ITER_MAX-1:0] mant_in,
    input  logic signed [6:0]   exp_in,
    output logic                it_valid,
    output logic                result,
    output logic                sign_out,
    output logic signed [6:0]   exp_out,
    output logic [ITER_MAX-1:0] mant_out,
    output logic                is_nan_out,
    output logic                is_pinf_out,
    output logic                is_ninf_out
);

    localparam int c_AW = 2 * ITER_MAX;
    localparam int c_CW = $clog2(ITER_MAX + 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_MUL  = 2'd1;
    localparam logic [1:0] c_S_NORM = 2'd2;

    localparam logic [c_CW-1:0]     c_CNT_INIT = c_CW'(ITER_MAX);
    localparam logic [c_CW-1:0]     c_CNT_ONE  = c_CW'(1);
    localparam logic signed [6:0]   c_EXP_INF  = 7'sd16;
    localparam logic signed [6:0]   c_EXP_ZERO = -7'sd15;
    localparam logic [ITER_MAX-1:0] c_MANT_NAN = {1'b1, {(ITER_MAX-1){1'b0}}};

    logic [1:0]          r_state;
    logic [c_CW-1:0]     r_cnt;
    logic [c_AW-1:0]     r_acc;
    logic [c_AW-1:0]     r_mcand;
    logic [ITER_MAX-1:0] r_mplier;
    logic signed [7:0]   r_exp2;

    logic                w_special;
    logic                w_nan_class;
    logic                w_zero;
    logic                w_hi;
    logic [ITER_MAX-1:0] w_norm_mant;
    logic signed [8:0]   w_norm_exp;
    logic                w_unused_sign;

    // A square is never negative, so the operand sign has no effect.
    assign w_unused_sign = sign_in;
    assign sign_out      = 1'b0;
    assign is_ninf_out   = 1'b0;

    assign w_special   = !is_num || is_nan_in || is_pinf_in || is_ninf_in;
    // Non-numbers that are not flagged infinite are reported as NaN.
    assign w_nan_class = is_nan_in || !(is_pinf_in || is_ninf_in);
    assign w_zero      = (exp_in == c_EXP_ZERO) && (mant_in == '0);

    assign w_hi        = r_acc[c_AW-1];
    assign w_norm_mant = w_hi ? r_acc[c_AW-1 -: ITER_MAX] : r_acc[c_AW-2 -: ITER_MAX];
    assign w_norm_exp  = {r_exp2[7], r_exp2} + {8'd0, w_hi};

    assign it_valid = (r_state != c_S_IDLE) || result;

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_state     <= c_S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_exp2      <= '0;
            result      <= 1'b0;
            exp_out     <= '0;
            mant_out    <= '0;
            is_nan_out  <= 1'b0;
            is_pinf_out <= 1'b0;
        end else begin
            result <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (n_valid) begin
                        if (w_special) begin
                            result      <= 1'b1;
                            exp_out     <= c_EXP_INF;
                            mant_out    <= w_nan_class ? c_MANT_NAN : '0;
                            is_nan_out  <= w_nan_class;
                            is_pinf_out <= !w_nan_class;
                        end else if (w_zero) begin
                            result      <= 1'b1;
                            exp_out     <= c_EXP_ZERO;
                            mant_out    <= '0;
                            is_nan_out  <= 1'b0;
                            is_pinf_out <= 1'b0;
                        end else begin
                            r_mcand  <= {{ITER_MAX{1'b0}}, mant_in};
                            r_mplier <= mant_in;
                            r_acc    <= '0;
                            r_exp2   <= {exp_in, 1'b0};
                            r_cnt    <= c_CNT_INIT;
                            r_state  <= c_S_MUL;
                        end
                    end
                end
                c_S_MUL: begin
                    // Keeping the multiplicand pre-shifted avoids a barrel shifter.
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_state <= c_S_NORM;
                    end
                end
                c_S_NORM: begin
                    result  <= 1'b1;
                    r_state <= c_S_IDLE;
                    if (w_norm_exp > 9'sd15) begin
                        exp_out     <= c_EXP_INF;
                        mant_out    <= '0;
                        is_nan_out  <= 1'b0;
                        is_pinf_out <= 1'b1;
                    end else if (w_norm_exp < -9'sd14) begin
                        exp_out     <= c_EXP_ZERO;
                        mant_out    <= '0;
                        is_nan_out  <= 1'b0;
                        is_pinf_out <= 1'b0;
                    end else begin
                        exp_out     <= w_norm_exp[6:0];
                        mant_out    <= w_norm_mant;
                        is_nan_out  <= 1'b0;
                        is_pinf_out <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iterate_square.sv
`default_nettype none
// ============================================================================
// Module   : tb_iterate_square
// Brief    : Self-checking bench for iterate_square against a latency/arith
//            reference model plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iterate_square;

    localparam int W = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst = 1'b1;
    logic                enable = 1'b1;
    logic                n_valid = 1'b0;
    logic                is_nan_in = 1'b0;
    logic                is_pinf_in = 1'b0;
    logic                is_ninf_in = 1'b0;
    logic                is_num = 1'b1;
    logic                sign_in = 1'b0;
    logic [W-1:0]        mant_in = '0;
    logic signed [6:0]   exp_in = '0;

    logic                it_valid;
    logic                result;
    logic                sign_out;
    logic signed [6:0]   exp_out;
    logic [W-1:0]        mant_out;
    logic                is_nan_out;
    logic                is_pinf_out;
    logic                is_ninf_out;

    iterate_square #(.ITER_MAX(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .n_valid     (n_valid),
        .is_nan_in   (is_nan_in),
        .is_pinf_in  (is_pinf_in),
        .is_ninf_in  (is_ninf_in),
        .is_num      (is_num),
        .sign_in     (sign_in),
        .mant_in     (mant_in),
        .exp_in      (exp_in),
        .it_valid    (it_valid),
        .result      (result),
        .sign_out    (sign_out),
        .exp_out     (exp_out),
        .mant_out    (mant_out),
        .is_nan_out  (is_nan_out),
        .is_pinf_out (is_pinf_out),
        .is_ninf_out (is_ninf_out)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: expected outputs and the countdown to a pending result.
    logic         m_result = 1'b0, m_itvalid = 1'b0, m_nan = 1'b0, m_pinf = 1'b0;
    logic [6:0]   m_exp = '0;
    logic [W-1:0] m_mant = '0;
    logic         p_nan = 1'b0, p_pinf = 1'b0;
    logic [6:0]   p_exp = '0;
    logic [W-1:0] p_mant = '0;
    int           m_busy = 0;

    task automatic set_model_out(input logic nan, input logic pinf, input logic [6:0] e,
                                 input logic [W-1:0] m);
        m_nan = nan; m_pinf = pinf; m_exp = e; m_mant = m;
    endtask

    task automatic square_model();
        longint p;
        int     e;
        p = longint'(mant_in) * longint'(mant_in);
        e = 2 * int'(exp_in);
        if (((p >> (2 * W - 1)) & 64'd1) != 0) begin
            p_mant = W'(p >> W);
            e++;
        end else begin
            p_mant = W'(p >> (W - 1));
        end
        p_nan = 1'b0; p_pinf = 1'b0; p_exp = 7'(e);
        if (e > 15) begin
            p_pinf = 1'b1; p_exp = 7'd16; p_mant = '0;
        end else if (e < -14) begin
            p_exp = 7'h71; p_mant = '0;
        end
    endtask

    task automatic model_step();
        m_result = 1'b0;
        if (rst || !enable) begin
            m_busy = 0;
            set_model_out(1'b0, 1'b0, 7'd0, '0);
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_result = 1'b1;
                set_model_out(p_nan, p_pinf, p_exp, p_mant);
            end
        end else if (n_valid) begin
            if (is_nan_in) begin
                m_result = 1'b1; set_model_out(1'b1, 1'b0, 7'd16, W'(1) << (W - 1));
            end else if (is_pinf_in || is_ninf_in) begin
                m_result = 1'b1; set_model_out(1'b0, 1'b1, 7'd16, '0);
            end else if (!is_num) begin
                m_result = 1'b1; set_model_out(1'b1, 1'b0, 7'd16, W'(1) << (W - 1));
            end else if (exp_in == -15 && mant_in == '0) begin
                m_result = 1'b1; set_model_out(1'b0, 1'b0, 7'h71, '0);
            end else begin
                square_model();
                m_busy = W + 1;
            end
        end
        m_itvalid = (m_busy > 0) || m_result;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("result",   result,   m_result);
            check("it_valid", it_valid, m_itvalid);
            check("sign_out", sign_out, 0);
            check("exp_out",  {25'd0, exp_out}, {25'd0, m_exp});
            check("mant_out", mant_out, m_mant);
            check("nan_out",  is_nan_out,  m_nan);
            check("pinf_out", is_pinf_out, m_pinf);
            check("ninf_out", is_ninf_out, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        n_valid = 1'b0; is_nan_in = 1'b0; is_pinf_in = 1'b0; is_ninf_in = 1'b0;
        is_num = 1'b1; sign_in = 1'b0;
    endtask

    // cls: 0 number, 1 NaN, 2 +inf, 3 -inf
    task automatic issue(input logic [W-1:0] m, input int e, input logic s, input int cls);
        idle_inputs();
        mant_in = m; exp_in = 7'(e); sign_in = s; n_valid = 1'b1;
        is_nan_in = (cls == 1); is_pinf_in = (cls == 2); is_ninf_in = (cls == 3);
        tick();
        idle_inputs();
    endtask

    // Returns edges from the accept edge (counted as 1) to the result pulse.
    task automatic wait_result(output int lat);
        int n;
        n = 1;
        while (!result && n < 40) begin
            tick();
            n++;
        end
        if (!result) begin
            checks++; failures++;
            $display("FAIL timeout: no result within %0d edges", n);
        end
        lat = n;
    endtask

    task automatic abort_test(input bit use_rst);
        int lat;
        issue(W'(11'h600), 0, 1'b0, 0);
        repeat (5) tick();
        if (use_rst) rst = 1'b1; else enable = 1'b0;
        tick();
        rst = 1'b0; enable = 1'b1;
        check("abort_it_valid", it_valid, 0);
        check("abort_result",   result,   0);
        check("abort_mant",     mant_out, 0);
        issue(W'(11'h7FF), 0, 1'b0, 0);
        wait_result(lat);
        check("abort_next_lat",  lat, W + 2);
        check("abort_next_mant", mant_out, 11'h7FE);
        check("abort_next_exp",  {25'd0, exp_out}, 1);
    endtask

    initial begin
        int lat, nres, first_res, ivcnt, r, cls;
        idle_inputs();
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_result",   result,   0);
        check("rst_it_valid", it_valid, 0);
        check("rst_exp",      {25'd0, exp_out}, 0);
        check("rst_mant",     mant_out, 0);
        rst = 1'b0;

        issue(W'(11'h600), 0, 1'b0, 0);
        wait_result(lat);
        check("sq15_lat",  lat, 13);
        check("sq15_mant", mant_out, 11'h480);
        check("sq15_exp",  {25'd0, exp_out}, 1);
        check("sq15_flag", {is_nan_out, is_pinf_out}, 0);
        tick();
        check("pulse_one_cycle", result, 0);

        issue(W'(11'h400), -8, 1'b0, 0);
        wait_result(lat);
        check("under_exp",  {25'd0, exp_out}, 7'h71);
        check("under_mant", mant_out, 0);
        issue(W'(11'h400), 8, 1'b0, 0);
        wait_result(lat);
        check("over_exp",  {25'd0, exp_out}, 16);
        check("over_pinf", is_pinf_out, 1);

        issue(W'(11'h400), 0, 1'b1, 3);
        wait_result(lat);
        check("ninf_lat",  lat, 1);
        check("ninf_pinf", is_pinf_out, 1);
        check("ninf_exp",  {25'd0, exp_out}, 16);
        issue(W'(11'h400), 0, 1'b0, 1);
        wait_result(lat);
        check("nan_flag", is_nan_out, 1);
        check("nan_mant", mant_out, 11'h400);
        issue(W'(0), -15, 1'b1, 0);
        wait_result(lat);
        check("zero_lat",  lat, 1);
        check("zero_exp",  {25'd0, exp_out}, 7'h71);
        check("zero_mant", mant_out, 0);

        // A second strobe during the multiply must be ignored.
        issue(W'(11'h600), 0, 1'b0, 0);
        nres = 0; first_res = 0; ivcnt = it_valid ? 1 : 0;
        for (int k = 2; k <= 20; k++) begin
            if (k == 6) begin
                n_valid = 1'b1; mant_in = W'(11'h7FF); exp_in = 7'sd3;
            end else begin
                idle_inputs();
            end
            tick();
            if (result) begin
                nres++;
                if (first_res == 0) first_res = k;
            end
            if (it_valid) ivcnt++;
        end
        check("busy_pulses",   nres, 1);
        check("busy_res_edge", first_res, 13);
        check("busy_it_valid", ivcnt, 13);
        check("busy_mant",     mant_out, 11'h480);

        abort_test(1'b1);
        abort_test(1'b0);

        for (int i = 0; i < 2500; i++) begin
            r = int'($urandom_range(0, 99));
            rst = (r == 0);
            enable = (r != 1);
            n_valid = ($urandom_range(0, 2) != 0);
            cls = int'($urandom_range(0, 19));
            is_nan_in = (cls == 0); is_pinf_in = (cls == 1); is_ninf_in = (cls == 2);
            is_num = (cls != 3);
            sign_in = 1'($urandom);
            mant_in = W'($urandom);
            if ($urandom_range(0, 7) != 0) mant_in[W-1] = 1'b1;
            if ($urandom_range(0, 4) == 0) exp_in = 7'($urandom);
            else exp_in = 7'(int'($urandom_range(0, 18)) - 9);
            if (cls == 4) begin
                mant_in = '0; exp_in = -7'sd15;
            end
            tick();
        end
        rst = 1'b0; enable = 1'b1; idle_inputs();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
